// File: rtl/game_sequencer.sv
// game_sequencer: top-level game state machine. It derives a frame tick from the
// display vertical count, grants mover strobes round-robin, and tracks lives and
// the win/lose outcome.
module game_sequencer #(
  parameter int unsigned LIVES        = 3,
  parameter int unsigned DYING_FRAMES = 60
) (
  input  logic       board_clk,
  input  logic       Reset,
  input  logic       start,
  input  logic       ack,
  input  logic [9:0] vCount,
  input  logic       hit,
  input  logic       allEaten,
  input  logic [3:0] ghostActive,
  output logic [2:0] state,
  output logic [4:0] moveEn,
  output logic       respawn,
  output logic [1:0] lives,
  output logic       win,
  output logic       lose
);

  localparam int unsigned CNT_W = 8;
  localparam logic [1:0]       LIVES_INIT = 2'(LIVES);
  localparam logic [CNT_W-1:0] DYING_LAST = CNT_W'(DYING_FRAMES);

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_PLAY  = 3'd1,
    ST_DYING = 3'd2,
    ST_WIN   = 3'd3,
    ST_LOSE  = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       lives_q, lives_d;
  logic [4:0]       move_en_q, move_en_d;
  logic             respawn_q, respawn_d;
  logic             win_q, win_d;
  logic             lose_q, lose_d;
  logic [CNT_W-1:0] dcnt_q, dcnt_d;
  logic [1:0]       last_q, last_d;
  logic [9:0]       vcount_prev_q;

  logic             frame_tick_c;
  logic             grant_valid_c;
  logic [1:0]       grant_idx_c;
  logic [1:0]       cand_c;

  // One-cycle frame tick on the nonzero -> zero edge of the vertical count
  assign frame_tick_c = (vCount == 10'd0) && (vcount_prev_q != 10'd0);

  // Round-robin search for the next active ghost, starting after the last grant
  always_comb begin
    grant_valid_c = 1'b0;
    grant_idx_c   = last_q;
    cand_c        = last_q;
    for (int k = 1; k <= 4; k++) begin
      cand_c = last_q + 2'(k);
      if (!grant_valid_c && ghostActive[cand_c]) begin
        grant_valid_c = 1'b1;
        grant_idx_c   = cand_c;
      end
    end
  end

  // Next-state and registered-output logic for the game FSM
  always_comb begin
    state_d   = state_q;
    lives_d   = lives_q;
    move_en_d = 5'd0;
    respawn_d = 1'b0;
    dcnt_d    = dcnt_q;
    last_d    = last_q;

    case (state_q)
      ST_INIT: begin
        lives_d = LIVES_INIT;
        if (start) begin
          state_d   = ST_PLAY;
          respawn_d = 1'b1;
        end
      end
      ST_PLAY: begin
        if (allEaten) begin
          state_d = ST_WIN;
        end else if (hit) begin
          state_d = ST_DYING;
          lives_d = (lives_q != 2'd0) ? lives_q - 2'd1 : 2'd0;
          dcnt_d  = '0;
        end else if (frame_tick_c) begin
          move_en_d[0] = 1'b1;
          if (grant_valid_c) begin
            move_en_d[4:1] = 4'(4'b0001 << grant_idx_c);
            last_d         = grant_idx_c;
          end
        end
      end
      ST_DYING: begin
        if (frame_tick_c) begin
          dcnt_d = dcnt_q + CNT_W'(1);
          if ((dcnt_q + CNT_W'(1)) == DYING_LAST) begin
            if (lives_q == 2'd0) begin
              state_d = ST_LOSE;
            end else begin
              state_d   = ST_PLAY;
              respawn_d = 1'b1;
            end
          end
        end
      end
      ST_WIN, ST_LOSE: begin
        if (ack) begin
          state_d = ST_INIT;
          lives_d = LIVES_INIT;
        end
      end
      default: begin
        state_d = ST_INIT;
        lives_d = LIVES_INIT;
      end
    endcase

    win_d  = (state_d == ST_WIN);
    lose_d = (state_d == ST_LOSE);
  end

  // State and output registers, asynchronously cleared by Reset
  always_ff @(posedge board_clk or posedge Reset) begin
    if (Reset) begin
      state_q       <= ST_INIT;
      lives_q       <= LIVES_INIT;
      move_en_q     <= 5'd0;
      respawn_q     <= 1'b0;
      win_q         <= 1'b0;
      lose_q        <= 1'b0;
      dcnt_q        <= '0;
      last_q        <= 2'd3;
      vcount_prev_q <= 10'd0;
    end else begin
      state_q       <= state_d;
      lives_q       <= lives_d;
      move_en_q     <= move_en_d;
      respawn_q     <= respawn_d;
      win_q         <= win_d;
      lose_q        <= lose_d;
      dcnt_q        <= dcnt_d;
      last_q        <= last_d;
      vcount_prev_q <= vCount;
    end
  end

  assign state   = state_q;
  assign moveEn  = move_en_q;
  assign respawn = respawn_q;
  assign lives   = lives_q;
  assign win     = win_q;
  assign lose    = lose_q;

endmodule

// File: tb/tb_game_sequencer.sv
// tb_game_sequencer: directed and randomized checks of game_sequencer against
// a behavioural model of lives, outcome and ghost round-robin.
module tb_game_sequencer;

  localparam int unsigned DF = 2;

  localparam int S_INIT  = 0;
  localparam int S_PLAY  = 1;
  localparam int S_DYING = 2;
  localparam int S_WIN   = 3;
  localparam int S_LOSE  = 4;

  logic       board_clk = 1'b0;
  logic       Reset;
  logic       start;
  logic       ack;
  logic [9:0] vCount;
  logic       hit;
  logic       allEaten;
  logic [3:0] ghostActive;
  logic [2:0] state;
  logic [4:0] moveEn;
  logic       respawn;
  logic [1:0] lives;
  logic       win;
  logic       lose;

  int n_cmp = 0;
  int n_err = 0;

  // Model: last granted ghost number (1..4) and remaining lives
  int m_last;
  int m_lives;

  game_sequencer #(.LIVES(3), .DYING_FRAMES(DF)) dut (
    .board_clk  (board_clk),
    .Reset      (Reset),
    .start      (start),
    .ack        (ack),
    .vCount     (vCount),
    .hit        (hit),
    .allEaten   (allEaten),
    .ghostActive(ghostActive),
    .state      (state),
    .moveEn     (moveEn),
    .respawn    (respawn),
    .lives      (lives),
    .win        (win),
    .lose       (lose)
  );

  always #5 board_clk = ~board_clk;

  task automatic tick();
    @(posedge board_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected strobes for one PLAY frame: pacman always, plus next active ghost
  function automatic logic [4:0] model_grant(input logic [3:0] act);
    logic [4:0] r;
    r = 5'b00001;
    for (int n = 1; n <= 4; n++) begin
      int g;
      g = ((m_last - 1 + n) % 4) + 1;
      if (act[g-1]) begin
        m_last = g;
        r = r | 5'(1 << g);
        return r;
      end
    end
    return r;
  endfunction

  task automatic make_tick_edge();
    vCount = 10'($urandom_range(1, 524));
    tick();
    vCount = 10'd0;
    tick();
  endtask

  task automatic frame_play(input string tag);
    logic [4:0] exp;
    make_tick_edge();
    exp = model_grant(ghostActive);
    check({tag, "_moveEn"}, 32'(moveEn), 32'(exp));
    check({tag, "_state"}, 32'(state), S_PLAY);
    check({tag, "_respawn"}, 32'(respawn), 0);
    tick();
    check({tag, "_moveEn_off"}, 32'(moveEn), 0);
  endtask

  task automatic frame_idle(input string tag, input int exp_state);
    make_tick_edge();
    check({tag, "_moveEn"}, 32'(moveEn), 0);
    check({tag, "_state"}, 32'(state), 32'(exp_state));
  endtask

  task automatic do_start(input string tag);
    start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, "_state"}, 32'(state), S_PLAY);
    check({tag, "_respawn"}, 32'(respawn), 1);
    tick();
    check({tag, "_respawn_off"}, 32'(respawn), 0);
  endtask

  task automatic do_hit(input string tag, input bit with_frame);
    if (with_frame) begin
      vCount = 10'd300;
      tick();
      vCount = 10'd0;
    end
    hit = 1'b1;
    tick();
    hit = 1'b0;
    m_lives = (m_lives > 0) ? m_lives - 1 : 0;
    check({tag, "_state"}, 32'(state), S_DYING);
    check({tag, "_lives"}, 32'(lives), 32'(m_lives));
    check({tag, "_moveEn"}, 32'(moveEn), 0);
  endtask

  task automatic dying_out(input string tag);
    for (int f = 1; f <= int'(DF); f++) begin
      make_tick_edge();
      check($sformatf("%s_f%0d_moveEn", tag, f), 32'(moveEn), 0);
      if (f < int'(DF)) begin
        check($sformatf("%s_f%0d_state", tag, f), 32'(state), S_DYING);
      end else begin
        check({tag, "_exit_state"}, 32'(state), (m_lives == 0) ? S_LOSE : S_PLAY);
        check({tag, "_exit_respawn"}, 32'(respawn), (m_lives == 0) ? 0 : 1);
        check({tag, "_exit_lose"}, 32'(lose), (m_lives == 0) ? 1 : 0);
      end
    end
    tick();
    check({tag, "_respawn_off"}, 32'(respawn), 0);
    check({tag, "_lives"}, 32'(lives), 32'(m_lives));
  endtask

  initial begin
    Reset = 1'b1; start = 1'b0; ack = 1'b0; vCount = 10'd0;
    hit = 1'b0; allEaten = 1'b0; ghostActive = 4'hF;
    m_last = 4; m_lives = 3;
    repeat (3) tick();
    check("rst_state", 32'(state), S_INIT);
    check("rst_lives", 32'(lives), 3);
    check("rst_moveEn", 32'(moveEn), 0);
    check("rst_respawn", 32'(respawn), 0);
    check("rst_win", 32'(win), 0);
    check("rst_lose", 32'(lose), 0);
    Reset = 1'b0;
    tick();

    // ack ignored in INIT
    ack = 1'b1; tick(); ack = 1'b0;
    check("init_ack_state", 32'(state), S_INIT);
    check("init_lives", 32'(lives), 3);

    // Start with all ghosts active, then five frames
    ghostActive = 4'b1111;
    do_start("start1");
    repeat (2) begin
      tick();
      check("no_tick_moveEn", 32'(moveEn), 0);
    end
    for (int i = 0; i < 5; i++) frame_play($sformatf("all_fr%0d", i));

    // Sparse mask, then none, then reactivation
    ghostActive = 4'b0101;
    for (int i = 0; i < 4; i++) frame_play($sformatf("m0101_fr%0d", i));
    ghostActive = 4'b0000;
    for (int i = 0; i < 2; i++) frame_play($sformatf("m0000_fr%0d", i));
    ghostActive = 4'b1111;
    for (int i = 0; i < 2; i++) frame_play($sformatf("react_fr%0d", i));

    // Randomized masks and gaps
    for (int i = 0; i < 16; i++) begin
      ghostActive = 4'($urandom_range(0, 15));
      repeat ($urandom_range(0, 3)) begin
        vCount = 10'($urandom_range(1, 524));
        tick();
      end
      frame_play($sformatf("rnd_fr%0d", i));
    end

    // Three deaths down to LOSE; first hit coincides with a frame tick
    do_hit("hit1", 1'b1);
    hit = 1'b1; allEaten = 1'b1; tick(); hit = 1'b0; allEaten = 1'b0;
    check("dying_ignore_state", 32'(state), S_DYING);
    check("dying_ignore_lives", 32'(lives), 32'(m_lives));
    dying_out("die1");
    frame_play("after_die1");
    do_hit("hit2", 1'b0);
    dying_out("die2");
    do_hit("hit3", 1'b0);
    dying_out("die3");
    frame_idle("lose_frame", S_LOSE);
    start = 1'b1; tick(); start = 1'b0;
    check("lose_start_state", 32'(state), S_LOSE);
    check("lose_flag", 32'(lose), 1);
    ack = 1'b1; tick(); ack = 1'b0;
    m_lives = 3;
    check("lose_ack_state", 32'(state), S_INIT);
    check("lose_ack_lives", 32'(lives), 3);
    check("lose_ack_flag", 32'(lose), 0);

    // Simultaneous hit and allEaten: WIN wins, lives unchanged
    do_start("start2");
    frame_play("pre_win");
    hit = 1'b1; allEaten = 1'b1; tick(); hit = 1'b0; allEaten = 1'b0;
    check("win_state", 32'(state), S_WIN);
    check("win_flag", 32'(win), 1);
    check("win_lives", 32'(lives), 3);
    frame_idle("win_frame", S_WIN);
    start = 1'b1; tick(); start = 1'b0;
    check("win_start_state", 32'(state), S_WIN);
    ack = 1'b1; tick(); ack = 1'b0;
    check("win_ack_state", 32'(state), S_INIT);
    check("win_ack_flag", 32'(win), 0);
    check("win_ack_lives", 32'(lives), 3);

    // Reset asserted mid-DYING
    do_start("start3");
    do_hit("hit4", 1'b0);
    frame_idle("dying_partial", S_DYING);
    Reset = 1'b1;
    #1;
    check("mid_rst_state", 32'(state), S_INIT);
    check("mid_rst_lives", 32'(lives), 3);
    check("mid_rst_respawn", 32'(respawn), 0);
    check("mid_rst_moveEn", 32'(moveEn), 0);
    m_last = 4; m_lives = 3;
    repeat (2) tick();
    Reset = 1'b0;
    repeat (2) begin
      tick();
      check("post_rst_state", 32'(state), S_INIT);
      check("post_rst_respawn", 32'(respawn), 0);
    end
    do_start("start4");
    repeat (2) begin
      tick();
      check("post_rst_no_tick", 32'(moveEn), 0);
    end
    ghostActive = 4'($urandom_range(0, 15));
    frame_play("post_rst_fr0");
    frame_play("post_rst_fr1");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
